// File: rtl/ex_stage_vec.sv
// ex_stage_vec: N-lane vector execute stage between decode and memory.
// Scalar ALU, internal condition-code register, and branch resolve with
// squash of the next accepted instruction. All state updates on the
// falling clock edge; I_RESET is asynchronous, active high.
// Build option: EX_STAGE_MUL_EN compiles in the iterative shift-add
// multiplier (OP_MUL_D), which holds O_EX_Stall high while busy.
// Ports:
//   I_CLOCK, I_RESET, I_LOCK (run enable), I_GPUStallSignal (hold)
//   I_DE_Valid, I_Opcode, I_PC, I_Src1Value, I_Src2Value, I_Imm,
//   I_DestRegIdx, I_DestVRegIdx, I_Idx, I_VecSrc1Value, I_VecSrc2Value
//   O_EX_Stall, O_BranchPC_Signal, O_BranchAddrSelect_Signal (comb)
//   O_EX_Valid, O_Opcode, O_PC, O_DestRegIdx, O_DestVRegIdx,
//   O_DestValue, O_VecDestValue, O_RegWEn, O_VRegWEn, O_CCWEn,
//   O_CCValue (registered)
module ex_stage_vec #(
    parameter int LANES         = 4,
    parameter int LANE_W        = 16,
    parameter int REG_W         = 32,
    parameter int MUL_STEPS     = 4,
    parameter int OPCODE_WIDTH  = 8,
    parameter int PC_WIDTH      = 16,
    parameter int VREG_ID_WIDTH = 6
) (
    input  logic                     I_CLOCK,
    input  logic                     I_RESET,
    input  logic                     I_LOCK,
    input  logic                     I_DE_Valid,
    input  logic [OPCODE_WIDTH-1:0]  I_Opcode,
    input  logic [PC_WIDTH-1:0]      I_PC,
    input  logic [REG_W-1:0]         I_Src1Value,
    input  logic [REG_W-1:0]         I_Src2Value,
    input  logic [REG_W-1:0]         I_Imm,
    input  logic [3:0]               I_DestRegIdx,
    input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
    input  logic [$clog2(LANES)-1:0] I_Idx,
    input  logic [LANES*LANE_W-1:0]  I_VecSrc1Value,
    input  logic [LANES*LANE_W-1:0]  I_VecSrc2Value,
    input  logic                     I_GPUStallSignal,
    output logic                     O_EX_Stall,
    output logic                     O_EX_Valid,
    output logic                     O_RegWEn,
    output logic                     O_VRegWEn,
    output logic                     O_CCWEn,
    output logic [OPCODE_WIDTH-1:0]  O_Opcode,
    output logic [PC_WIDTH-1:0]      O_PC,
    output logic [3:0]               O_DestRegIdx,
    output logic [VREG_ID_WIDTH-1:0] O_DestVRegIdx,
    output logic [REG_W-1:0]         O_DestValue,
    output logic [LANES*LANE_W-1:0]  O_VecDestValue,
    output logic [2:0]               O_CCValue,
    output logic [PC_WIDTH-1:0]      O_BranchPC_Signal,
    output logic                     O_BranchAddrSelect_Signal
);

    localparam int OW = OPCODE_WIDTH;
    localparam int VW = LANES * LANE_W;

    localparam logic [OW-1:0] OP_ADD_D     = OW'('h01);
    localparam logic [OW-1:0] OP_ADDI_D    = OW'('h02);
    localparam logic [OW-1:0] OP_AND_D     = OW'('h03);
    localparam logic [OW-1:0] OP_ANDI_D    = OW'('h04);
    localparam logic [OW-1:0] OP_MOV       = OW'('h05);
    localparam logic [OW-1:0] OP_MOVI_D    = OW'('h06);
    localparam logic [OW-1:0] OP_CMP       = OW'('h07);
    localparam logic [OW-1:0] OP_CMPI      = OW'('h08);
    localparam logic [OW-1:0] OP_VADD      = OW'('h10);
    localparam logic [OW-1:0] OP_VMOV      = OW'('h11);
    localparam logic [OW-1:0] OP_VMOVI     = OW'('h12);
    localparam logic [OW-1:0] OP_VCOMPMOV  = OW'('h13);
    localparam logic [OW-1:0] OP_VCOMPMOVI = OW'('h14);
    localparam logic [OW-1:0] OP_BRN       = OW'('h20);
    localparam logic [OW-1:0] OP_BRZ       = OW'('h21);
    localparam logic [OW-1:0] OP_BRP       = OW'('h22);
    localparam logic [OW-1:0] OP_BRNZ      = OW'('h23);
    localparam logic [OW-1:0] OP_BRNP      = OW'('h24);
    localparam logic [OW-1:0] OP_BRZP      = OW'('h25);
    localparam logic [OW-1:0] OP_BRNZP     = OW'('h26);
    localparam logic [OW-1:0] OP_HALT      = OW'('h30);
`ifdef EX_STAGE_MUL_EN
    localparam logic [OW-1:0] OP_MUL_D     = OW'('h40);
`endif

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    logic              valid_q, valid_d;
    logic              reg_wen_q, reg_wen_d;
    logic              vreg_wen_q, vreg_wen_d;
    logic              cc_wen_q, cc_wen_d;
    logic [OW-1:0]     opcode_q, opcode_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [3:0]        dest_idx_q, dest_idx_d;
    logic [VREG_ID_WIDTH-1:0] dest_vidx_q, dest_vidx_d;
    logic [REG_W-1:0]  dest_value_q, dest_value_d;
    logic [VW-1:0]     vec_value_q, vec_value_d;
    logic [2:0]        cc_q, cc_d;
    logic              squash_q, squash_d;

    logic              mul_busy;
    logic              accept;
    logic [2:0]        br_mask;
    logic              is_halt;
    logic              br_taken;
    logic [PC_WIDTH-1:0] br_off;

`ifdef EX_STAGE_MUL_EN
    localparam int MUL_K  = REG_W / MUL_STEPS;
    localparam int STEP_W = $clog2(MUL_STEPS + 1);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MUL_BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [REG_W-1:0]  acc_q, acc_d;
    logic [REG_W-1:0]  mcand_q, mcand_d;
    logic [REG_W-1:0]  mplier_q, mplier_d;
    logic [REG_W-1:0]  mul_sum;

    assign mul_busy = (state_q == ST_MUL_BUSY);
`else
    assign mul_busy = 1'b0;
`endif

    function automatic logic [2:0] cc_of(input logic [REG_W-1:0] v);
        if (v == '0)
            return CC_Z;
        else if (v[REG_W-1])
            return CC_N;
        else
            return CC_P;
    endfunction

    assign O_EX_Stall = I_GPUStallSignal | mul_busy;
    assign accept     = I_LOCK & I_DE_Valid & ~O_EX_Stall;

    always_comb begin
        br_mask = 3'b000;
        is_halt = 1'b0;
        case (I_Opcode)
            OP_BRN:   br_mask = CC_N;
            OP_BRZ:   br_mask = CC_Z;
            OP_BRP:   br_mask = CC_P;
            OP_BRNZ:  br_mask = CC_N | CC_Z;
            OP_BRNP:  br_mask = CC_N | CC_P;
            OP_BRZP:  br_mask = CC_Z | CC_P;
            OP_BRNZP: br_mask = CC_N | CC_Z | CC_P;
            OP_HALT:  is_halt = 1'b1;
            default:  ;
        endcase
    end

    // cc_q already holds the previous instruction's CC, so a branch
    // right behind a CC writer sees the fresh value.
    assign br_taken = I_LOCK & I_DE_Valid & ~squash_q &
                      ((|(br_mask & cc_q)) | is_halt);
    assign br_off   = PC_WIDTH'($signed(I_Imm)) << 2;

    assign O_BranchAddrSelect_Signal = br_taken;
    assign O_BranchPC_Signal = is_halt ? (I_PC - PC_WIDTH'(4))
                                       : (I_PC + br_off);

    always_comb begin
        valid_d      = valid_q;
        reg_wen_d    = reg_wen_q;
        vreg_wen_d   = vreg_wen_q;
        cc_wen_d     = cc_wen_q;
        opcode_d     = opcode_q;
        pc_d         = pc_q;
        dest_idx_d   = dest_idx_q;
        dest_vidx_d  = dest_vidx_q;
        dest_value_d = dest_value_q;
        vec_value_d  = vec_value_q;
        cc_d         = cc_q;
        squash_d     = squash_q;
`ifdef EX_STAGE_MUL_EN
        state_d      = state_q;
        step_d       = step_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        mul_sum      = acc_q;
`endif
        if (!I_LOCK) begin
            valid_d    = 1'b0;
            reg_wen_d  = 1'b0;
            vreg_wen_d = 1'b0;
            cc_wen_d   = 1'b0;
`ifdef EX_STAGE_MUL_EN
            state_d    = ST_IDLE;
`endif
        end else if (I_GPUStallSignal) begin
            // downstream hold: every register keeps its value
        end
`ifdef EX_STAGE_MUL_EN
        else if (state_q == ST_MUL_BUSY) begin
            valid_d    = 1'b0;
            reg_wen_d  = 1'b0;
            vreg_wen_d = 1'b0;
            cc_wen_d   = 1'b0;
            for (int j = 0; j < MUL_K; j++) begin
                if (mplier_q[j])
                    mul_sum = mul_sum + (mcand_q << j);
            end
            acc_d    = mul_sum;
            mcand_d  = mcand_q << MUL_K;
            mplier_d = mplier_q >> MUL_K;
            step_d   = step_q + 1'b1;
            if (step_q == STEP_W'(MUL_STEPS - 1)) begin
                state_d      = ST_IDLE;
                valid_d      = 1'b1;
                reg_wen_d    = 1'b1;
                cc_wen_d     = 1'b1;
                dest_value_d = mul_sum;
                cc_d         = cc_of(mul_sum);
            end
        end
`endif
        else if (accept) begin
            opcode_d    = I_Opcode;
            pc_d        = I_PC;
            dest_idx_d  = I_DestRegIdx;
            dest_vidx_d = I_DestVRegIdx;
            valid_d     = 1'b1;
            reg_wen_d   = 1'b0;
            vreg_wen_d  = 1'b0;
            cc_wen_d    = 1'b0;
            if (squash_q) begin
                valid_d  = 1'b0;
                squash_d = 1'b0;
            end else begin
                squash_d = br_taken;
                case (I_Opcode)
                    OP_ADD_D, OP_ADDI_D, OP_AND_D,
                    OP_ANDI_D, OP_MOV, OP_MOVI_D: begin
                        case (I_Opcode)
                            OP_ADD_D:  dest_value_d = I_Src1Value + I_Src2Value;
                            OP_ADDI_D: dest_value_d = I_Src1Value + I_Imm;
                            OP_AND_D:  dest_value_d = I_Src1Value & I_Src2Value;
                            OP_ANDI_D: dest_value_d = I_Src1Value & I_Imm;
                            OP_MOV:    dest_value_d = I_Src1Value;
                            default:   dest_value_d = I_Imm;
                        endcase
                        reg_wen_d = 1'b1;
                        cc_wen_d  = 1'b1;
                        cc_d      = cc_of(dest_value_d);
                    end
                    OP_CMP, OP_CMPI: begin
                        dest_value_d = I_Src1Value -
                            ((I_Opcode == OP_CMP) ? I_Src2Value : I_Imm);
                        cc_wen_d = 1'b1;
                        cc_d     = cc_of(dest_value_d);
                    end
                    OP_VADD: begin
                        for (int l = 0; l < LANES; l++) begin
                            vec_value_d[l*LANE_W +: LANE_W] =
                                I_VecSrc1Value[l*LANE_W +: LANE_W] +
                                I_VecSrc2Value[l*LANE_W +: LANE_W];
                        end
                        vreg_wen_d = 1'b1;
                    end
                    OP_VMOV: begin
                        vec_value_d = I_VecSrc1Value;
                        vreg_wen_d  = 1'b1;
                    end
                    OP_VMOVI: begin
                        vec_value_d = {LANES{I_Imm[LANE_W-1:0]}};
                        vreg_wen_d  = 1'b1;
                    end
                    OP_VCOMPMOV, OP_VCOMPMOVI: begin
                        vec_value_d = I_VecSrc1Value;
                        vec_value_d[I_Idx*LANE_W +: LANE_W] =
                            (I_Opcode == OP_VCOMPMOV) ?
                            I_Src1Value[LANE_W-1:0] : I_Imm[LANE_W-1:0];
                        vreg_wen_d = 1'b1;
                    end
`ifdef EX_STAGE_MUL_EN
                    OP_MUL_D: begin
                        valid_d  = 1'b0;
                        state_d  = ST_MUL_BUSY;
                        step_d   = '0;
                        acc_d    = '0;
                        mcand_d  = I_Src1Value;
                        mplier_d = I_Src2Value;
                    end
`endif
                    default: ;
                endcase
            end
        end else begin
            valid_d    = 1'b0;
            reg_wen_d  = 1'b0;
            vreg_wen_d = 1'b0;
            cc_wen_d   = 1'b0;
        end
    end

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            valid_q      <= 1'b0;
            reg_wen_q    <= 1'b0;
            vreg_wen_q   <= 1'b0;
            cc_wen_q     <= 1'b0;
            opcode_q     <= '0;
            pc_q         <= '0;
            dest_idx_q   <= '0;
            dest_vidx_q  <= '0;
            dest_value_q <= '0;
            vec_value_q  <= '0;
            cc_q         <= CC_Z;
            squash_q     <= 1'b0;
`ifdef EX_STAGE_MUL_EN
            state_q      <= ST_IDLE;
            step_q       <= '0;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
`endif
        end else begin
            valid_q      <= valid_d;
            reg_wen_q    <= reg_wen_d;
            vreg_wen_q   <= vreg_wen_d;
            cc_wen_q     <= cc_wen_d;
            opcode_q     <= opcode_d;
            pc_q         <= pc_d;
            dest_idx_q   <= dest_idx_d;
            dest_vidx_q  <= dest_vidx_d;
            dest_value_q <= dest_value_d;
            vec_value_q  <= vec_value_d;
            cc_q         <= cc_d;
            squash_q     <= squash_d;
`ifdef EX_STAGE_MUL_EN
            state_q      <= state_d;
            step_q       <= step_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
`endif
        end
    end

    assign O_EX_Valid     = valid_q;
    assign O_RegWEn       = reg_wen_q;
    assign O_VRegWEn      = vreg_wen_q;
    assign O_CCWEn        = cc_wen_q;
    assign O_Opcode       = opcode_q;
    assign O_PC           = pc_q;
    assign O_DestRegIdx   = dest_idx_q;
    assign O_DestVRegIdx  = dest_vidx_q;
    assign O_DestValue    = dest_value_q;
    assign O_VecDestValue = vec_value_q;
    assign O_CCValue      = cc_q;

endmodule

// File: tb/tb_ex_stage_vec.sv
// Directed bench for ex_stage_vec (default parameters). Registers move
// on the falling edge; inputs change and outputs are sampled 1ns after it.
module tb_ex_stage_vec;

    localparam logic [7:0] OP_ADD_D = 8'h01, OP_ADDI_D = 8'h02;
    localparam logic [7:0] OP_AND_D = 8'h03, OP_ANDI_D = 8'h04;
    localparam logic [7:0] OP_MOV = 8'h05, OP_MOVI_D = 8'h06;
    localparam logic [7:0] OP_CMP = 8'h07, OP_CMPI = 8'h08;
    localparam logic [7:0] OP_VADD = 8'h10, OP_VMOV = 8'h11;
    localparam logic [7:0] OP_VMOVI = 8'h12, OP_VCOMPMOV = 8'h13;
    localparam logic [7:0] OP_VCOMPMOVI = 8'h14;
    localparam logic [7:0] OP_BRN = 8'h20, OP_BRZ = 8'h21, OP_BRP = 8'h22;
    localparam logic [7:0] OP_BRNZP = 8'h26, OP_HALT = 8'h30;
    localparam logic [7:0] OP_MUL_D = 8'h40, OP_UNK = 8'hEE;

    logic        clk = 1'b0;
    logic        rst, lock, de_valid, gpu_stall;
    logic [7:0]  i_op;
    logic [15:0] i_pc;
    logic [31:0] i_s1, i_s2, i_imm;
    logic [3:0]  i_dst;
    logic [5:0]  i_vdst;
    logic [1:0]  i_idx;
    logic [63:0] i_v1, i_v2;
    logic        o_stall, o_valid, o_rwen, o_vwen, o_ccwen;
    logic [7:0]  o_op;
    logic [15:0] o_pc, o_bpc;
    logic [3:0]  o_dst;
    logic [5:0]  o_vdst;
    logic [31:0] o_val;
    logic [63:0] o_vec;
    logic [2:0]  o_cc;
    logic        o_bsel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_stage_vec dut (
        .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock),
        .I_DE_Valid(de_valid), .I_Opcode(i_op), .I_PC(i_pc),
        .I_Src1Value(i_s1), .I_Src2Value(i_s2), .I_Imm(i_imm),
        .I_DestRegIdx(i_dst), .I_DestVRegIdx(i_vdst), .I_Idx(i_idx),
        .I_VecSrc1Value(i_v1), .I_VecSrc2Value(i_v2),
        .I_GPUStallSignal(gpu_stall), .O_EX_Stall(o_stall),
        .O_EX_Valid(o_valid), .O_RegWEn(o_rwen), .O_VRegWEn(o_vwen),
        .O_CCWEn(o_ccwen), .O_Opcode(o_op), .O_PC(o_pc),
        .O_DestRegIdx(o_dst), .O_DestVRegIdx(o_vdst),
        .O_DestValue(o_val), .O_VecDestValue(o_vec), .O_CCValue(o_cc),
        .O_BranchPC_Signal(o_bpc), .O_BranchAddrSelect_Signal(o_bsel)
    );

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [15:0] pc,
                         input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] imm);
        i_op = op; i_pc = pc; i_s1 = s1; i_s2 = s2; i_imm = imm;
        de_valid = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; lock = 1'b0; de_valid = 1'b0; gpu_stall = 1'b0;
        i_op = 8'h00; i_pc = '0; i_s1 = '0; i_s2 = '0; i_imm = '0;
        i_dst = 4'd5; i_vdst = 6'd0; i_idx = 2'd0; i_v1 = '0; i_v2 = '0;
        tick;
        rst = 1'b0; lock = 1'b1;
        drive(OP_MOVI_D, 16'h0020, 0, 0, 32'h1234);
        tick;
        checks++; if (o_val !== 32'h1234) begin errors++;
            $display("FAIL pre_reset_val: got %h want %h", o_val, 32'h1234); end
        de_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_val !== 32'h0) begin errors++;
            $display("FAIL reset_val: got %h want 0", o_val); end
        checks++; if ({o_rwen, o_vwen, o_ccwen} !== 3'b000) begin errors++;
            $display("FAIL reset_wen: got %b want 000", {o_rwen, o_vwen, o_ccwen}); end
        checks++; if ({o_op, o_pc, o_dst} !== 28'h0) begin errors++;
            $display("FAIL reset_copies: got %h want 0", {o_op, o_pc, o_dst}); end
        checks++; if (o_cc !== 3'b010) begin errors++;
            $display("FAIL reset_cc: got %b want 010", o_cc); end
        rst = 1'b0;
    endtask

    task automatic test_scalar;
        i_dst = 4'd3;
        drive(OP_ADDI_D, 16'h0010, 5, 0, 32'hFFFFFFF9);
        tick;
        checks++; if (o_val !== 32'hFFFFFFFE) begin errors++;
            $display("FAIL addi_val: got %h want fffffffe", o_val); end
        checks++; if (o_cc !== 3'b100) begin errors++;
            $display("FAIL addi_cc: got %b want 100", o_cc); end
        checks++; if ({o_valid, o_rwen, o_ccwen, o_vwen} !== 4'b1110) begin errors++;
            $display("FAIL addi_flags: got %b want 1110", {o_valid, o_rwen, o_ccwen, o_vwen}); end
        checks++; if ({o_dst, o_pc} !== {4'd3, 16'h0010}) begin errors++;
            $display("FAIL addi_copies: got %h want 30010", {o_dst, o_pc}); end
        drive(OP_BRN, 16'h0040, 0, 0, 3);
        checks++; if (o_bsel !== 1'b1) begin errors++;
            $display("FAIL brn_sel: got %b want 1", o_bsel); end
        checks++; if (o_bpc !== 16'h004C) begin errors++;
            $display("FAIL brn_target: got %h want 004c", o_bpc); end
        tick;
        checks++; if ({o_valid, o_rwen, o_ccwen} !== 3'b100) begin errors++;
            $display("FAIL brn_out: got %b want 100", {o_valid, o_rwen, o_ccwen}); end
        drive(OP_ADD_D, 16'h0044, 1, 2, 0);
        tick;
        checks++; if ({o_valid, o_rwen, o_ccwen} !== 3'b000) begin errors++;
            $display("FAIL squash_out: got %b want 000", {o_valid, o_rwen, o_ccwen}); end
        checks++; if (o_cc !== 3'b100 || o_val !== 32'hFFFFFFFE) begin errors++;
            $display("FAIL squash_hold: got cc %b val %h want 100 fffffffe", o_cc, o_val); end
        drive(OP_ADD_D, 16'h0048, 1, 2, 0);
        tick;
        checks++; if (o_val !== 32'd3 || o_cc !== 3'b001) begin errors++;
            $display("FAIL add_after: got %h/%b want 3/001", o_val, o_cc); end
        drive(OP_ANDI_D, 16'h004C, 32'hF0F0, 0, 32'h0FF0);
        tick;
        checks++; if (o_val !== 32'h00F0) begin errors++;
            $display("FAIL andi_val: got %h want 000000f0", o_val); end
        drive(OP_AND_D, 16'h0050, 32'hFFFF0000, 32'h0F0F0F0F, 0);
        tick;
        checks++; if (o_val !== 32'h0F0F0000) begin errors++;
            $display("FAIL and_val: got %h want 0f0f0000", o_val); end
        drive(OP_MOV, 16'h0054, 32'h80000000, 0, 0);
        tick;
        checks++; if (o_val !== 32'h80000000 || o_cc !== 3'b100) begin errors++;
            $display("FAIL mov: got %h/%b want 80000000/100", o_val, o_cc); end
        drive(OP_CMP, 16'h0058, 5, 5, 0);
        tick;
        checks++; if ({o_rwen, o_ccwen, o_cc} !== 5'b01010) begin errors++;
            $display("FAIL cmp: got %b want 01010", {o_rwen, o_ccwen, o_cc}); end
    endtask

    task automatic test_back_to_back;
        drive(OP_BRZ, 16'h0080, 0, 0, 32'hFFFFFFFF);
        checks++; if (o_bsel !== 1'b1 || o_bpc !== 16'h007C) begin errors++;
            $display("FAIL brz_fwd: got %b/%h want 1/007c", o_bsel, o_bpc); end
        tick;
        drive(OP_UNK, 16'h0084, 0, 0, 0);
        tick;
        checks++; if (o_valid !== 1'b0) begin errors++;
            $display("FAIL brz_squash: got %b want 0", o_valid); end
        drive(OP_CMPI, 16'h0088, 3, 0, 9);
        tick;
        checks++; if (o_cc !== 3'b100 || o_rwen !== 1'b0) begin errors++;
            $display("FAIL cmpi: got %b/%b want 100/0", o_cc, o_rwen); end
        drive(OP_BRP, 16'h008C, 0, 0, 4);
        checks++; if (o_bsel !== 1'b0) begin errors++;
            $display("FAIL brp_not_taken: got %b want 0", o_bsel); end
        tick;
        drive(OP_UNK, 16'h0090, 0, 0, 0);
        tick;
        checks++; if ({o_valid, o_rwen, o_vwen, o_ccwen} !== 4'b1000) begin errors++;
            $display("FAIL unknown_nop: got %b want 1000", {o_valid, o_rwen, o_vwen, o_ccwen}); end
        drive(OP_HALT, 16'h0100, 0, 0, 0);
        checks++; if (o_bsel !== 1'b1 || o_bpc !== 16'h00FC) begin errors++;
            $display("FAIL halt: got %b/%h want 1/00fc", o_bsel, o_bpc); end
        tick;
        drive(OP_BRN, 16'h0104, 0, 0, 1);
        checks++; if (o_bsel !== 1'b0) begin errors++;
            $display("FAIL squashed_branch_sel: got %b want 0", o_bsel); end
        tick;
        checks++; if (o_valid !== 1'b0) begin errors++;
            $display("FAIL halt_squash: got %b want 0", o_valid); end
        de_valid = 1'b0;
        i_op = OP_BRNZP;
        #1;
        checks++; if (o_bsel !== 1'b0) begin errors++;
            $display("FAIL br_invalid: got %b want 0", o_bsel); end
        tick;
    endtask

    task automatic test_vector;
        i_vdst = 6'd7;
        i_v1 = 64'h0003_0002_0001_FFFF;
        i_v2 = 64'h0001_0001_0001_0001;
        drive(OP_VADD, 16'h0200, 0, 0, 0);
        tick;
        checks++; if (o_vec !== 64'h0004_0003_0002_0000) begin errors++;
            $display("FAIL vadd: got %h want 0004000300020000", o_vec); end
        checks++; if ({o_vwen, o_ccwen, o_rwen, o_cc} !== 6'b100100) begin errors++;
            $display("FAIL vadd_flags: got %b want 100100", {o_vwen, o_ccwen, o_rwen, o_cc}); end
        checks++; if (o_vdst !== 6'd7) begin errors++;
            $display("FAIL vdst: got %0d want 7", o_vdst); end
        i_v1 = 64'h1111_2222_3333_4444;
        i_idx = 2'd2;
        drive(OP_VCOMPMOVI, 16'h0204, 0, 0, 32'h0000ABCD);
        tick;
        checks++; if (o_vec !== 64'h1111_ABCD_3333_4444) begin errors++;
            $display("FAIL vcompmovi: got %h want 1111abcd33334444", o_vec); end
        drive(OP_VMOVI, 16'h0208, 0, 0, 32'h00005A5A);
        tick;
        checks++; if (o_vec !== 64'h5A5A_5A5A_5A5A_5A5A) begin errors++;
            $display("FAIL vmovi: got %h want 5a5a5a5a5a5a5a5a", o_vec); end
        i_idx = 2'd0;
        drive(OP_VCOMPMOV, 16'h020C, 32'h00009876, 0, 0);
        tick;
        checks++; if (o_vec !== 64'h1111_2222_3333_9876) begin errors++;
            $display("FAIL vcompmov: got %h want 1111222233339876", o_vec); end
        i_v1 = 64'hDEAD_BEEF_CAFE_F00D;
        drive(OP_VMOV, 16'h0210, 0, 0, 0);
        tick;
        checks++; if (o_vec !== 64'hDEAD_BEEF_CAFE_F00D) begin errors++;
            $display("FAIL vmov: got %h want deadbeefcafef00d", o_vec); end
    endtask

    task automatic test_lock_stall;
        drive(OP_MOVI_D, 16'h0300, 0, 0, 32'h55);
        tick;
        drive(OP_ADD_D, 16'h0304, 32'h10, 32'h20, 0);
        gpu_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (o_stall !== 1'b1) begin errors++;
                $display("FAIL stall_out[%0d]: got %b want 1", i, o_stall); end
            tick;
            checks++; if (o_val !== 32'h55 || o_valid !== 1'b1) begin errors++;
                $display("FAIL stall_hold[%0d]: got %h/%b want 55/1", i, o_val, o_valid); end
        end
        gpu_stall = 1'b0;
        tick;
        checks++; if (o_val !== 32'h30 || o_pc !== 16'h0304) begin errors++;
            $display("FAIL stall_release: got %h/%h want 30/0304", o_val, o_pc); end
        lock = 1'b0;
        drive(OP_ADD_D, 16'h0308, 1, 1, 0);
        tick;
        checks++; if ({o_valid, o_rwen} !== 2'b00 || o_val !== 32'h30) begin errors++;
            $display("FAIL lock_low: got %b/%h want 00/30", {o_valid, o_rwen}, o_val); end
        drive(OP_BRNZP, 16'h030C, 0, 0, 1);
        checks++; if (o_bsel !== 1'b0) begin errors++;
            $display("FAIL lock_branch: got %b want 0", o_bsel); end
        lock = 1'b1;
        de_valid = 1'b0;
        tick;
    endtask

    task automatic test_mul;
`ifdef EX_STAGE_MUL_EN
        i_dst = 4'd9;
        drive(OP_MUL_D, 16'h0400, 7, 32'hFFFFFFFD, 0);
        tick;
        checks++; if ({o_valid, o_rwen} !== 2'b00) begin errors++;
            $display("FAIL mul_accept_bubble: got %b want 00", {o_valid, o_rwen}); end
        i_dst = 4'd2;
        drive(OP_ADD_D, 16'h0404, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (o_stall !== 1'b1) begin errors++;
                $display("FAIL mul_stall[%0d]: got %b want 1", i, o_stall); end
            tick;
            if (i < 3) begin
                checks++; if ({o_valid, o_rwen} !== 2'b00) begin errors++;
                    $display("FAIL mul_bubble[%0d]: got %b want 00", i, {o_valid, o_rwen}); end
            end
        end
        checks++; if (o_val !== 32'hFFFFFFEB || o_cc !== 3'b100) begin errors++;
            $display("FAIL mul_result: got %h/%b want ffffffeb/100", o_val, o_cc); end
        checks++; if ({o_valid, o_rwen, o_ccwen, o_dst} !== {3'b111, 4'd9}) begin errors++;
            $display("FAIL mul_flags: got %b want 1111001", {o_valid, o_rwen, o_ccwen, o_dst}); end
        checks++; if (o_stall !== 1'b0) begin errors++;
            $display("FAIL mul_done_stall: got %b want 0", o_stall); end
        tick;
        checks++; if (o_val !== 32'd2 || o_pc !== 16'h0404) begin errors++;
            $display("FAIL mul_next_add: got %h/%h want 2/0404", o_val, o_pc); end
        drive(OP_MUL_D, 16'h0408, 6, 5, 0);
        tick;
        de_valid = 1'b0;
        tick; tick; tick;
        gpu_stall = 1'b1;
        tick; tick;
        checks++; if (o_valid !== 1'b0 || o_val !== 32'd2) begin errors++;
            $display("FAIL mul_final_hold: got %b/%h want 0/2", o_valid, o_val); end
        gpu_stall = 1'b0;
        #1;
        checks++; if (o_stall !== 1'b1) begin errors++;
            $display("FAIL mul_still_busy: got %b want 1", o_stall); end
        tick;
        checks++; if (o_val !== 32'h1E || o_valid !== 1'b1 || o_cc !== 3'b001) begin errors++;
            $display("FAIL mul_release: got %h/%b/%b want 1e/1/001", o_val, o_valid, o_cc); end
        drive(OP_MUL_D, 16'h040C, 3, 3, 0);
        tick;
        de_valid = 1'b0;
        tick;
        lock = 1'b0;
        tick;
        checks++; if (o_valid !== 1'b0 || o_stall !== 1'b0) begin errors++;
            $display("FAIL mul_lock_abort: got %b/%b want 0/0", o_valid, o_stall); end
        lock = 1'b1;
        tick;
        checks++; if (o_valid !== 1'b0 || o_stall !== 1'b0) begin errors++;
            $display("FAIL mul_lock_idle: got %b/%b want 0/0", o_valid, o_stall); end
        drive(OP_MUL_D, 16'h0410, 3, 3, 0);
        tick;
        de_valid = 1'b0;
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        checks++; if (o_stall !== 1'b0 || o_cc !== 3'b010) begin errors++;
            $display("FAIL mul_reset_abort: got %b/%b want 0/010", o_stall, o_cc); end
`else
        drive(OP_MUL_D, 16'h0400, 7, 32'hFFFFFFFD, 0);
        checks++; if (o_stall !== 1'b0) begin errors++;
            $display("FAIL mul_off_stall: got %b want 0", o_stall); end
        tick;
        checks++; if ({o_valid, o_rwen, o_ccwen} !== 3'b100) begin errors++;
            $display("FAIL mul_off_nop: got %b want 100", {o_valid, o_rwen, o_ccwen}); end
        checks++; if (o_val !== 32'h30 || o_stall !== 1'b0) begin errors++;
            $display("FAIL mul_off_hold: got %h/%b want 30/0", o_val, o_stall); end
        de_valid = 1'b0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_scalar;
        test_back_to_back;
        test_vector;
        test_lock_stall;
        test_mul;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage_vec.md
# ex_stage_vec

Parametrised execute stage for the GPU-frame pipeline, sitting between decode (DE) and memory (MEM). It generalises the scalar execute stage to an N-lane vector datapath with configurable lane width. It adds an internal condition-code register, taken-branch squash of the following instruction, and an optional iterative multi-cycle multiplier. The multiplier back-pressures DE through a stall output.

## Interface
Parameters:
- `LANES`, 4, vector lane count (power of two, ≥2)
- `LANE_W`, 16, bits per lane
- `REG_W`, 32, scalar register width
- `MUL_STEPS`, 4, multiplier iterations; `REG_W % MUL_STEPS == 0`

Ports (opcode, PC and VREG-ID widths come from `global_def.h`):
- `I_CLOCK` in 1: clock; all registers update on the falling edge
- `I_RESET` in 1: asynchronous, active-high reset
- `I_LOCK` in 1: pipeline run enable
- `I_DE_Valid` in 1: input instruction valid
- `I_Opcode` in `OPCODE_WIDTH`
- `I_PC` in `PC_WIDTH`
- `I_Src1Value`, `I_Src2Value`, `I_Imm` in `REG_W`: `I_Imm` is already sign-extended
- `I_DestRegIdx` in 4
- `I_DestVRegIdx` in `VREG_ID_WIDTH`
- `I_Idx` in clog2(`LANES`): lane select
- `I_VecSrc1Value`, `I_VecSrc2Value` in `LANES*LANE_W`: lane 0 in the LSBs
- `I_GPUStallSignal` in 1: downstream stall
- `O_EX_Stall` out 1: combinational; DE must hold its inputs while this is high
- `O_EX_Valid`, `O_RegWEn`, `O_VRegWEn`, `O_CCWEn` out 1
- `O_Opcode`, `O_PC`, `O_DestRegIdx`, `O_DestVRegIdx` out: registered copies of the inputs
- `O_DestValue` out `REG_W`
- `O_VecDestValue` out `LANES*LANE_W`
- `O_CCValue` out 3
- `O_BranchPC_Signal` out `PC_WIDTH`: combinational
- `O_BranchAddrSelect_Signal` out 1: combinational

## Operation
- **Accept rule:** an instruction is accepted on an edge when `I_LOCK & I_DE_Valid & !O_EX_Stall`.
- **Scalar ops:** `ADD_D`/`ADDI_D` add; `AND_D`/`ANDI_D` bitwise AND; `MOV`/`MOVI_D` copy. Each sets `RegWEn=1` and `CCWEn=1`.
- **Compare ops:** `CMP`/`CMPI` compute Src1−Src2 or Src1−Imm with `RegWEn=0` and `CCWEn=1`.
- **CC encoding:** derived from the signed `REG_W` result: P=001, Z=010, N=100.
- **Internal CC register:** updated on accept when `CCWEn`; reset value 010. `O_CCValue` is always the post-instruction CC.
- **Vector ops** (all set `VRegWEn=1`, `CCWEn=0`):
  - `VADD`: lane-wise add, mod 2^`LANE_W`.
  - `VMOV`: copy `VecSrc1`.
  - `VMOVI`: broadcast `I_Imm[LANE_W-1:0]` to every lane.
  - `VCOMPMOV` / `VCOMPMOVI`: copy `VecSrc1` with lane `I_Idx` replaced by `Src1[LANE_W-1:0]` or `Imm[LANE_W-1:0]`.
- **Branches `BRN`…`BRNZP`:** the opcode defines a mask (N=100, Z=010, P=001, and ORs for combinations).
  - Taken when `mask & CC` is nonzero, the instruction is valid, and it is not squashed.
  - Target is `I_PC + (I_Imm<<2)`.
- **`HALT`:** always selects `I_PC − 4`.
- **Squash:** the first valid instruction accepted after a taken branch or HALT is squashed. It produces `O_EX_Valid=0`, all WEn=0, and no CC update.
- **Unknown opcodes** are NOPs: valid passes through, all WEn=0.
- **Multiplier FSM `IDLE → MUL_BUSY → IDLE`** (opcode `OP_MUL_D`, defined in `global_def.h`):
  - Accepting `OP_MUL_D` latches the operands, clears the accumulator, and enters `MUL_BUSY` with `step=0`.
  - Each edge in `MUL_BUSY` adds `REG_W/MUL_STEPS` multiplier bits (shift-add).
  - On the step that reaches `MUL_STEPS`, the stage writes the low `REG_W` bits of the product with `RegWEn=1` and `CCWEn=1`, then returns to `IDLE`.
  - If `I_GPUStallSignal` is high on that step, the FSM holds the final result until the stall drops.
- `O_EX_Stall = I_GPUStallSignal | (state==MUL_BUSY)`.

## Timing
- **Reset values:** `I_RESET` high forces all outputs to 0 except `O_CCValue`/CC = 010, FSM to `IDLE`, and the squash flag to 0. Asserting reset mid-multiply aborts it.
- **Single-cycle ops:** results appear on the output registers at the accept edge; latency is 1 edge.
- **Branch outputs:** `O_BranchAddrSelect_Signal` is combinational in the same cycle. It is 0 whenever `!I_LOCK` or `!I_DE_Valid`.
- **Multiplier latency:** accept at edge k, result at edge k+`MUL_STEPS` (if not stalled). Edges k through k+`MUL_STEPS`−1 emit bubbles (`Valid=0`, WEn=0).
- **`I_GPUStallSignal` high:** all output registers and the CC register hold.
- **`I_LOCK` low:** at each edge `O_EX_Valid` and all WEn are driven to 0, and the FSM returns to `IDLE`.
- **Back-to-back:** a branch can use the CC produced by the immediately preceding instruction, because the internal register is forwarded.

## Configuration
- `EX_STAGE_MUL_EN` defined: the multiplier FSM is compiled in, behaving as above.
- `EX_STAGE_MUL_EN` undefined: no FSM. `OP_MUL_D` is a NOP (all WEn=0, valid passes), and `O_EX_Stall = I_GPUStallSignal`.

## Test plan
- **Reset:** assert `I_RESET` mid-cycle → all outputs 0 immediately, `O_CCValue`=010.
- **Scalar ALU:** `ADDI_D` Src1=5, Imm=−7 → `O_DestValue`=0xFFFFFFFE, CC=100, `RegWEn`=1. Follow with `BRN` Imm=3 at PC=0x40 → `BranchAddrSelect`=1 and target 0x4C; the next instruction is squashed.
- **Vector, `LANES`=4, `LANE_W`=16:**
  - `VADD` lanes {0xFFFF,1,2,3}+{1,1,1,1} → {0,2,3,4}, `VRegWEn`=1, CC unchanged.
  - `VCOMPMOVI` `Idx`=2, Imm=0xABCD → only lane 2 changes.
- **Multiplier (macro on):** `MUL_D` 7×−3 → `O_EX_Stall` high for 4 edges, bubbles emitted, then `O_DestValue`=0xFFFFFFEB with CC=100. Assert `I_GPUStallSignal` on the final step → result held until release.
- **Multiplier (macro off):** `MUL_D` → NOP, no stall.
- **Lock and stall:** drop `I_LOCK` during `MUL_BUSY` → FSM returns to `IDLE` and Valid=0. Hold `I_GPUStallSignal` for 3 cycles with `ADD` pending → outputs unchanged, then the `ADD` completes.
